// File: rtl/munoc_svring_initiator.sv
// munoc_svring_initiator
// Register-access initiator for the service ring.
// A host request becomes one packet {cmd, node_id, index, wdata}. The packet is
// sent as link flits, MSB first. The block then waits for the matching
// {node_id, data} response and returns it to the host as a one-cycle pulse.
// Optional feature: define MUNOC_SVRING_INITIATOR_TIMEOUT_EN to add a response
// watchdog. Without it, WAIT has no limit and resp_error is tied low.

module munoc_svring_initiator #(
    parameter int BW_LINK        = 10,
    parameter int BW_NODE_ID     = 6,
    parameter int BW_REG_INDEX   = 6,
    parameter int BW_DATA        = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rstnn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [BW_NODE_ID-1:0]   req_node_id,
    input  logic [BW_REG_INDEX-1:0] req_index,
    input  logic [BW_DATA-1:0]      req_wdata,
    output logic                    resp_valid,
    output logic [BW_DATA-1:0]      resp_rdata,
    output logic                    resp_error,
    output logic [BW_LINK-1:0]      tx_link,
    input  logic                    tx_link_ready,
    input  logic [BW_LINK-1:0]      rx_link,
    output logic                    rx_link_ready
);

    localparam int PW      = BW_LINK - 2;                       // payload bits per flit
    localparam int REQ_W   = 2 + BW_NODE_ID + BW_REG_INDEX + BW_DATA;
    localparam int REQ_N   = (REQ_W + PW - 1) / PW;
    localparam int REQ_PAD = REQ_N * PW;
    localparam int RSP_W   = BW_NODE_ID + BW_DATA;
    localparam int RSP_N   = (RSP_W + PW - 1) / PW;
    localparam int RSP_PAD = RSP_N * PW;
    localparam int TXC_W   = $clog2(REQ_N + 1);
    localparam int RXC_W   = $clog2(RSP_N + 2);                 // headroom so an overlong packet saturates above RSP_N

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

    state_t                  state;
    logic [REQ_PAD-1:0]      tx_shift;       // flits not yet placed on tx_link
    logic [TXC_W-1:0]        tx_cnt;         // flits placed on tx_link so far
    logic [RSP_PAD-1:0]      rx_shift;
    logic [RXC_W-1:0]        rx_cnt;
    logic                    write_q;
    logic [BW_NODE_ID-1:0]   node_q;

    logic [REQ_W-1:0]        req_packet;
    logic [REQ_PAD-1:0]      req_padded;
    logic [RSP_PAD-1:0]      rx_next;
    logic [RSP_W-1:0]        rsp_packet;
    logic [RXC_W-1:0]        rx_cnt_next;
    logic                    rx_fire;
    logic                    rx_last;
    logic                    rsp_match;

`ifdef MUNOC_SVRING_INITIATOR_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] wait_cnt;
    logic            resp_error_q;
    assign resp_error = resp_error_q;
`else
    assign resp_error = 1'b0;
`endif

    // Build the outgoing packet and assemble the incoming one.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path; a missing default here would infer a latch.
        req_packet  = {(req_write ? 2'b10 : 2'b01), req_node_id, req_index,
                       (req_write ? req_wdata : {BW_DATA{1'b0}})};
        req_padded  = REQ_PAD'(req_packet) << (REQ_PAD - REQ_W);
        rx_fire     = rx_link_ready && rx_link[BW_LINK-1];
        rx_last     = rx_link[BW_LINK-2];
        rx_next     = (rx_shift << PW) | RSP_PAD'(rx_link[PW-1:0]);
        rsp_packet  = rx_next[RSP_PAD-1 -: RSP_W];
        rx_cnt_next = (rx_cnt == {RXC_W{1'b1}}) ? rx_cnt : rx_cnt + 1'b1;
        rsp_match   = (rsp_packet[RSP_W-1 -: BW_NODE_ID] == node_q)
                   && (rx_cnt_next == RXC_W'(RSP_N));
    end

    // Transaction FSM with registered handshake, link and response outputs.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state         <= IDLE;
            req_ready     <= 1'b0;
            tx_link       <= '0;
            tx_shift      <= '0;
            tx_cnt        <= '0;
            rx_link_ready <= 1'b0;
            rx_shift      <= '0;
            rx_cnt        <= '0;
            write_q       <= 1'b0;
            node_q        <= '0;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
`ifdef MUNOC_SVRING_INITIATOR_TIMEOUT_EN
            wait_cnt      <= '0;
            resp_error_q  <= 1'b0;
`endif
        end else begin
            // NOTE: state is assigned non-blocking only, so every branch reads the pre-edge values.
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        state     <= SEND;
                        req_ready <= 1'b0;
                        write_q   <= req_write;
                        node_q    <= req_node_id;
                        tx_link   <= {1'b1, (REQ_N == 1), req_padded[REQ_PAD-1 -: PW]};
                        tx_shift  <= req_padded << PW;
                        tx_cnt    <= TXC_W'(1);
                    end
                end
                SEND: begin
                    if (tx_link_ready) begin
                        if (tx_link[BW_LINK-2]) begin
                            state         <= WAIT;
                            tx_link       <= '0;
                            rx_link_ready <= 1'b1;
                            rx_shift      <= '0;
                            rx_cnt        <= '0;
`ifdef MUNOC_SVRING_INITIATOR_TIMEOUT_EN
                            wait_cnt      <= '0;
`endif
                        end else begin
                            tx_link  <= {1'b1, (tx_cnt == TXC_W'(REQ_N - 1)), tx_shift[REQ_PAD-1 -: PW]};
                            tx_shift <= tx_shift << PW;
                            tx_cnt   <= tx_cnt + 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (rx_fire) begin
                        if (rx_last && rsp_match) begin
                            state         <= DONE;
                            rx_link_ready <= 1'b0;
                            resp_valid    <= 1'b1;
                            resp_rdata    <= write_q ? '0 : rsp_packet[BW_DATA-1:0];
`ifdef MUNOC_SVRING_INITIATOR_TIMEOUT_EN
                            resp_error_q  <= 1'b0;
`endif
                            rx_shift      <= '0;
                            rx_cnt        <= '0;
                        end else if (rx_last) begin
                            // Foreign or malformed packet: drop it and keep listening.
                            rx_shift <= '0;
                            rx_cnt   <= '0;
                        end else begin
                            rx_shift <= rx_next;
                            rx_cnt   <= rx_cnt_next;
                        end
                    end
`ifdef MUNOC_SVRING_INITIATOR_TIMEOUT_EN
                    // A matching last flit in the expiry cycle takes priority over the timeout.
                    if (!(rx_fire && rx_last && rsp_match)) begin
                        if (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                            state         <= DONE;
                            rx_link_ready <= 1'b0;
                            resp_valid    <= 1'b1;
                            resp_rdata    <= '1;
                            resp_error_q  <= 1'b1;
                            rx_shift      <= '0;
                            rx_cnt        <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
`endif
                end
                DONE: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
`ifdef MUNOC_SVRING_INITIATOR_TIMEOUT_EN
                    resp_error_q <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_munoc_svring_initiator.sv
// Self-checking bench for munoc_svring_initiator.
// A packet-level model builds the expected flit streams and response values.
// Directed cases cover the interface scenarios, then randomized transactions follow.
`timescale 1ns/1ps

module tb_munoc_svring_initiator;

    localparam int BW_LINK        = 10;
    localparam int BW_NODE_ID     = 6;
    localparam int BW_REG_INDEX   = 6;
    localparam int BW_DATA        = 32;
    localparam int TIMEOUT_CYCLES = 1024;
    localparam int PW    = BW_LINK - 2;
    localparam int REQ_W = 2 + BW_NODE_ID + BW_REG_INDEX + BW_DATA;
    localparam int REQ_N = (REQ_W + PW - 1) / PW;
    localparam int RSP_W = BW_NODE_ID + BW_DATA;
    localparam int RSP_N = (RSP_W + PW - 1) / PW;

    typedef logic [PW-1:0] flit_t;

    logic                    clk = 1'b0;
    logic                    rstnn;
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [BW_NODE_ID-1:0]   req_node_id;
    logic [BW_REG_INDEX-1:0] req_index;
    logic [BW_DATA-1:0]      req_wdata;
    logic                    resp_valid;
    logic [BW_DATA-1:0]      resp_rdata;
    logic                    resp_error;
    logic [BW_LINK-1:0]      tx_link;
    logic                    tx_link_ready;
    logic [BW_LINK-1:0]      rx_link;
    logic                    rx_link_ready;

    int tests = 0;
    int fails = 0;
    flit_t exp_tx[$];

    munoc_svring_initiator #(
        .BW_LINK(BW_LINK), .BW_NODE_ID(BW_NODE_ID), .BW_REG_INDEX(BW_REG_INDEX),
        .BW_DATA(BW_DATA), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rstnn(rstnn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_node_id(req_node_id), .req_index(req_index), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .tx_link(tx_link), .tx_link_ready(tx_link_ready),
        .rx_link(rx_link), .rx_link_ready(rx_link_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs are then sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the packet is left-justified in whole flits and cut MSB first.
    task automatic model_request(input logic wr, input logic [BW_NODE_ID-1:0] node,
                                 input logic [BW_REG_INDEX-1:0] idx, input logic [BW_DATA-1:0] wd);
        logic [REQ_N*PW-1:0] pk;
        pk = {(wr ? 2'b10 : 2'b01), node, idx, (wr ? wd : {BW_DATA{1'b0}})};
        pk = pk << (REQ_N * PW - REQ_W);
        exp_tx.delete();
        for (int i = 0; i < REQ_N; i++) exp_tx.push_back(pk[(REQ_N-1-i)*PW +: PW]);
    endtask

    // Issue a request and collect its flits. Stall modes: 0 none, 1 four-cycle stall at flit 2, 2 random.
    task automatic issue(input logic wr, input logic [BW_NODE_ID-1:0] node,
                         input logic [BW_REG_INDEX-1:0] idx, input logic [BW_DATA-1:0] wd,
                         input int stall_mode);
        int cyc;
        int k;
        int stall_left;
        bit rdy;
        logic [BW_LINK-1:0] exp_flit;
        cyc = 0;
        while (req_ready !== 1'b1 && cyc < 50) begin step(); cyc++; end
        check("req_ready_idle", req_ready, 1);
        model_request(wr, node, idx, wd);
        req_valid = 1'b1; req_write = wr; req_node_id = node; req_index = idx; req_wdata = wd;
        step();
        req_valid = 1'b0; req_wdata = $urandom;
        check("req_ready_busy", req_ready, 0);
        k = 0; cyc = 0; stall_left = 4;
        while (k < REQ_N && cyc < 400) begin
            case (stall_mode)
                1:       rdy = !(k == 2 && stall_left > 0);
                2:       rdy = ($urandom_range(0, 3) != 0);
                default: rdy = 1'b1;
            endcase
            if (!rdy) stall_left--;
            tx_link_ready = rdy;
            exp_flit = {1'b1, 1'(k == REQ_N - 1), exp_tx[k]};
            check("tx_flit", tx_link, exp_flit);
            if (rdy) k++;
            step();
            cyc++;
        end
        check("tx_flit_count", k, REQ_N);
        tx_link_ready = 1'($urandom_range(0, 1));
        check("tx_quiet_in_wait", tx_link, 0);
        check("rx_ready_in_wait", rx_link_ready, 1);
    endtask

    // Drive a response packet of nflits flits (last on the final one), optionally with idle gaps.
    task automatic respond(input logic [BW_NODE_ID-1:0] node, input logic [BW_DATA-1:0] data,
                           input int nflits, input bit gaps);
        logic [RSP_N*PW-1:0] pk;
        flit_t f;
        pk = {node, data};
        pk = pk << (RSP_N * PW - RSP_W);
        for (int i = 0; i < nflits; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                rx_link = {1'b0, 1'b1, PW'($urandom)};
                step();
            end
            f = (i < RSP_N) ? pk[(RSP_N-1-i)*PW +: PW] : PW'($urandom);
            rx_link = {1'b1, 1'(i == nflits - 1), f};
            step();
        end
        rx_link = '0;
    endtask

    task automatic expect_resp(input logic [BW_DATA-1:0] exp_data, input logic exp_err);
        check("resp_valid_pulse", resp_valid, 1);
        check("resp_rdata", resp_rdata, exp_data);
        check("resp_error", resp_error, exp_err);
        step();
        check("resp_valid_one_cycle", resp_valid, 0);
        check("resp_rdata_held", resp_rdata, exp_data);
        check("req_ready_after_done", req_ready, 1);
    endtask

    task automatic expect_discard();
        check("no_resp_on_discard", resp_valid, 0);
        check("still_waiting", rx_link_ready, 1);
    endtask

    initial begin
        logic                    wr;
        logic [BW_NODE_ID-1:0]   node;
        logic [BW_NODE_ID-1:0]   fnode;
        logic [BW_REG_INDEX-1:0] idx;
        logic [BW_DATA-1:0]      wd;
        logic [BW_DATA-1:0]      rd;
        bit                      seen;
        int                      n;

        rstnn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_node_id = '0; req_index = '0;
        req_wdata = '0; tx_link_ready = 1'b0; rx_link = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_tx_link", tx_link, 0);
        check("rst_rx_ready", rx_link_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_resp_error", resp_error, 0);
        @(negedge clk) rstnn = 1'b1;
        step();
        check("req_ready_after_reset", req_ready, 1);

        // Write node 5 index 3: six flits, write response carries no data.
        issue(1'b1, 6'd5, 6'd3, 32'hDEADBEEF, 0);
        respond(6'd5, 32'hCAFEF00D, RSP_N, 1'b0);
        expect_resp(32'h0, 1'b0);

        // Read node 2 index 1: data returned and held afterwards.
        issue(1'b0, 6'd2, 6'd1, 32'h55AA55AA, 0);
        respond(6'd2, 32'h12345678, RSP_N, 1'b0);
        expect_resp(32'h12345678, 1'b0);
        repeat (3) step();
        check("rdata_held_idle", resp_rdata, 32'h12345678);

        // Back-pressure mid-packet holds the same flit.
        issue(1'b1, 6'd9, 6'd60, 32'h0BADF00D, 1);
        respond(6'd9, 32'hFFFF0000, RSP_N, 1'b1);
        expect_resp(32'h0, 1'b0);

        // Foreign node and short packet are ignored; the proper response then completes.
        issue(1'b0, 6'd2, 6'd7, 32'h0, 0);
        respond(6'd7, 32'hAAAAAAAA, RSP_N, 1'b0);
        expect_discard();
        respond(6'd2, 32'hBBBBBBBB, 3, 1'b0);
        expect_discard();
        respond(6'd2, 32'hBBBBBBBB, RSP_N + 2, 1'b0);
        expect_discard();
        respond(6'd2, 32'h9ABCDEF0, RSP_N, 1'b0);
        expect_resp(32'h9ABCDEF0, 1'b0);

        // Randomized transactions with random back-pressure, gaps and stray responses.
        for (int t = 0; t < 24; t++) begin
            wr   = 1'($urandom_range(0, 1));
            node = BW_NODE_ID'($urandom);
            idx  = BW_REG_INDEX'($urandom);
            wd   = $urandom;
            rd   = $urandom;
            issue(wr, node, idx, wd, 2);
            if ($urandom_range(0, 2) == 0) begin
                fnode = node ^ BW_NODE_ID'($urandom_range(1, (1 << BW_NODE_ID) - 1));
                respond(fnode, $urandom, RSP_N, 1'b1);
                expect_discard();
            end
            respond(node, rd, RSP_N, 1'b1);
            expect_resp(wr ? 32'h0 : rd, 1'b0);
        end

`ifdef MUNOC_SVRING_INITIATOR_TIMEOUT_EN
        // No response: timeout after exactly TIMEOUT_CYCLES cycles in WAIT.
        issue(1'b0, 6'd2, 6'd4, 32'h0, 0);
        n = 0;
        while (resp_valid !== 1'b1 && n < TIMEOUT_CYCLES + 50) begin step(); n++; end
        check("timeout_latency", n, TIMEOUT_CYCLES);
        expect_resp({BW_DATA{1'b1}}, 1'b1);
        // A matching last flit landing in the expiry cycle wins over the timeout.
        issue(1'b0, 6'd3, 6'd5, 32'h0, 0);
        repeat (TIMEOUT_CYCLES - RSP_N) step();
        respond(6'd3, 32'h13579BDF, RSP_N, 1'b0);
        expect_resp(32'h13579BDF, 1'b0);
`else
        // Without the watchdog the initiator waits indefinitely.
        issue(1'b0, 6'd2, 6'd4, 32'h0, 0);
        seen = 1'b0;
        for (int c = 0; c < TIMEOUT_CYCLES + 100; c++) begin
            step();
            seen |= (resp_valid === 1'b1);
        end
        check("no_timeout_resp", seen, 0);
        check("still_wait_no_timeout", rx_link_ready, 1);
        respond(6'd2, 32'h2468ACE0, RSP_N, 1'b0);
        expect_resp(32'h2468ACE0, 1'b0);
`endif

        // Reset while sending, after three flits have been accepted.
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin step(); n++; end
        req_valid = 1'b1; req_write = 1'b1; req_node_id = 6'd4; req_index = 6'd2; req_wdata = 32'h11112222;
        step();
        req_valid = 1'b0;
        tx_link_ready = 1'b1;
        repeat (3) step();
        tx_link_ready = 1'b0;
        check("send_before_reset", tx_link[BW_LINK-1], 1);
        #2 rstnn = 1'b0;
        #1;
        check("reset_tx_quiet", tx_link, 0);
        check("reset_req_ready_low", req_ready, 0);
        @(negedge clk) rstnn = 1'b1;
        step();
        check("req_ready_after_midreset", req_ready, 1);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            seen |= (resp_valid === 1'b1) || (tx_link[BW_LINK-1] === 1'b1);
        end
        check("no_activity_after_reset", seen, 0);
        check("rx_ready_idle_after_reset", rx_link_ready, 0);

        // Normal operation resumes.
        issue(1'b0, 6'd4, 6'd2, 32'h0, 2);
        respond(6'd4, 32'h600DCAFE, RSP_N, 1'b1);
        expect_resp(32'h600DCAFE, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/munoc_svring_initiator.md
MUNOC_SVRING_INITIATOR -- requirements
Module: munoc_svring_initiator

Interface
REQ-001 Parameter BW_LINK, default 10, link word width: bit[BW_LINK-1]=valid, bit[BW_LINK-2]=last, bits[BW_LINK-3:0]=payload.
REQ-002 Parameter BW_NODE_ID, default 6, target controller node id width.
REQ-003 Parameter BW_REG_INDEX, default 6, register word-index width (byte offset = index<<2).
REQ-004 Parameter BW_DATA, default 32, register data width.
REQ-005 Parameter TIMEOUT_CYCLES, default 1024, response wait limit in cycles.
REQ-006 Clock and reset SHALL be: one clock, clk; reset is asynchronous and active-low, rstnn.
REQ-007 clk  input  1  clock.
REQ-008 rstnn  input  1  asynchronous active-low reset.
REQ-009 req_valid  input  1  host request present.
REQ-010 req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-011 req_write  input  1  1=write, 0=read.
REQ-012 req_node_id  input  BW_NODE_ID  target node.
REQ-013 req_index  input  BW_REG_INDEX  register word index.
REQ-014 req_wdata  input  BW_DATA  write data (ignored for read).
REQ-015 resp_valid  output  1  one-cycle response pulse.
REQ-016 resp_rdata  output  BW_DATA  read data; held until next response.
REQ-017 resp_error  output  1  timeout flag, qualified by resp_valid.
REQ-018 tx_link  output  BW_LINK  request flits to ring.
REQ-019 tx_link_ready  input  1  ring accepts tx flit.
REQ-020 rx_link  input  BW_LINK  response flits from ring.
REQ-021 rx_link_ready  output  1  initiator accepts rx flit.

Function
REQ-022 Request packet SHALL be {cmd[1:0], node_id, index, wdata}, cmd write=2'b10, read=2'b01, wdata zero for reads; split into ceil(width/(BW_LINK-2)) flits, MSB first, zero-padded at LSB (defaults: 46 bits, 6 flits).
REQ-023 Response packet SHALL be {node_id, data}, same flit rules (defaults: 38 bits, 5 flits).
REQ-024 FSM states IDLE, SEND, WAIT, DONE; req_ready=1 only in IDLE.
REQ-025 IDLE: req_valid captures request into shift register, next state SEND.
REQ-026 SEND: tx_link valid=1, last=1 on final flit only; flit advances when tx_link_ready=1; after final flit accepted -> WAIT; tx_link valid=0 in all other states.
REQ-027 WAIT: rx_link_ready=1 (0 in all other states); each rx flit with valid=1 shifts in and increments flit count (saturating).
REQ-028 On last flit: node_id equal to request and count equal to expected -> DONE; otherwise packet discarded, count cleared, stay WAIT.
REQ-029 DONE: resp_valid=1 one cycle, resp_rdata=received data for read, 0 for write, resp_error=0; -> IDLE.
REQ-030 Request back-to-back: next req accepted in IDLE cycle following DONE; minimum one idle cycle between transactions.

Reset
REQ-031 rstnn low SHALL force IDLE, shift registers, counters zero, resp_valid=0, resp_rdata=0, resp_error=0, tx_link=0, rx_link_ready=0, req_ready=0 during reset, 1 after.
REQ-032 Reset mid-transaction SHALL abandon the packet with no response.

Configuration
REQ-033 Macro MUNOC_SVRING_INITIATOR_TIMEOUT_EN defined: counter clears on entering WAIT, increments each WAIT cycle; at TIMEOUT_CYCLES cycles without a matching response -> DONE with resp_error=1, resp_rdata all ones, partial packet dropped; matching last flit in the expiry cycle wins (resp_error=0).
REQ-034 Macro undefined: no counter, WAIT indefinite, resp_error tied 0.

Verification
REQ-035 Write node 5 index 3 data 0xDEADBEEF, tx_link_ready=1 -> 6 tx flits, last on 6th; response node 5 -> resp_valid pulse, rdata 0, error 0.
REQ-036 Read node 2 index 1, response {2,0x12345678} -> resp_rdata=0x12345678, error 0, held after pulse.
REQ-037 tx_link_ready low 4 cycles mid-packet -> same flit held, no duplicate/skip.
REQ-038 Response from node 7 during read of node 2 -> discarded, no resp_valid; later node 2 response completes.
REQ-039 Macro on, no response -> after 1024 WAIT cycles resp_valid, error 1, rdata 0xFFFFFFFF; macro off -> stays WAIT.
REQ-040 rstnn low in SEND after 3 flits -> tx valid 0 immediately, req_ready 1 after release, no response.
